// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one fixed-latency, single-port memory between instruction fetch (IF)
//   and the memory stage (M). M wins a simultaneous request unless the last
//   grant also went to M, so fetch cannot starve behind back-to-back loads.
//   Each access issues a one-cycle command in the grant cycle, then the
//   arbiter stays busy until the done cycle, LATENCY cycles later.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   if_req/if_addr           fetch request and address
//   if_rdata/if_done/if_err  fetch result, valid while if_done=1
//   stall_f                  if_req & ~if_done
//   m_req/m_wr/m_addr/m_wdata  memory-stage request (load or store)
//   m_rdata/m_done/m_err     data result, valid while m_done=1
//   stall_m                  m_req & ~m_done
//   mem_rd/mem_wr/mem_addr/mem_wdata  one-cycle command to the memory
//   mem_rdata/mem_err        memory response, valid LATENCY cycles after the command
module mem_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_err,
  output logic        stall_f,
  input  logic        m_req,
  input  logic        m_wr,
  input  logic [15:0] m_addr,
  input  logic [15:0] m_wdata,
  output logic [15:0] m_rdata,
  output logic        m_done,
  output logic        m_err,
  output logic        stall_m,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_err
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_M} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_m_q, last_m_d;
  logic       keep_q, keep_d;

  logic       grant_m, grant_if;
  logic       owner_req, keep_eff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      last_m_q <= 1'b0;
      keep_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_m_q <= last_m_d;
      keep_q   <= keep_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_m_d  = last_m_q;
    keep_d    = keep_q;
    grant_m   = 1'b0;
    grant_if  = 1'b0;
    owner_req = (state_q == BUSY_IF) ? if_req : m_req;
    keep_eff  = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0;
    mem_wdata = 16'h0;
    if_done   = 1'b0;
    if_err    = 1'b0;
    if_rdata  = 16'h0;
    m_done    = 1'b0;
    m_err     = 1'b0;
    m_rdata   = 16'h0;

    unique case (state_q)
      IDLE: begin
        // rst is checked here so no command leaks out while reset is held;
        // the flops alone would leave IDLE decoding live requests.
        if (rst) begin
          grant_m  = m_req & ~(if_req & last_m_q);
          grant_if = if_req & ~grant_m;
          if (grant_m) begin
            mem_wr    = m_wr;
            mem_rd    = ~m_wr;
            mem_addr  = m_addr;
            mem_wdata = m_wr ? m_wdata : 16'h0;
            state_d   = BUSY_M;
            cnt_d     = 4'd1;
            keep_d    = 1'b1;
            last_m_d  = 1'b1;
          end else if (grant_if) begin
            mem_rd   = 1'b1;
            mem_addr = if_addr;
            state_d  = BUSY_IF;
            cnt_d    = 4'd1;
            keep_d   = 1'b1;
            last_m_d = 1'b0;
          end
        end
      end
      BUSY_IF, BUSY_M: begin
        // A dropped request (e.g. a flushed fetch) abandons the result but the
        // access still occupies the memory until its done cycle.
        keep_eff = keep_q & owner_req;
        keep_d   = keep_eff;
        if (cnt_q == LAT) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          keep_d  = 1'b0;
          if (keep_eff) begin
            if (state_q == BUSY_IF) begin
              if_done  = 1'b1;
              if_rdata = mem_rdata;
              if_err   = mem_err;
            end else begin
              m_done  = 1'b1;
              m_rdata = mem_rdata;
              m_err   = mem_err;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        keep_d  = 1'b0;
      end
    endcase
  end

  assign stall_f = if_req & ~if_done;
  assign stall_m = m_req & ~m_done;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int LAT = 4;

  logic        clk, rst;
  logic        if_req, m_req, m_wr, mem_err;
  logic [15:0] if_addr, m_addr, m_wdata, mem_rdata;
  logic [15:0] if_rdata, m_rdata, mem_addr, mem_wdata;
  logic        if_done, if_err, stall_f, m_done, m_err, stall_m, mem_rd, mem_wr;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .if_err(if_err), .stall_f(stall_f),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done), .m_err(m_err), .stall_m(stall_m),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Tracks the one outstanding access by its grant timestamp; the access
  // finishes at grant time + LAT and the memory is free again after that.
  typedef struct packed {
    logic        mem_rd, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        if_done, if_err;
    logic [15:0] if_rdata;
    logic        m_done, m_err;
    logic [15:0] m_rdata;
    logic        stall_f, stall_m;
  } exp_t;

  int now = 0;
  int g_time = 0;
  int g_who = 0;      // 0 none, 1 fetch, 2 memory stage
  bit g_keep = 0;
  bit last_m = 0;

  function automatic int pick();
    if (m_req && !(if_req && last_m)) return 2;
    if (if_req) return 1;
    return 0;
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e = '0;
    if (rst) begin
      if (g_who != 0) begin
        if (now == g_time + LAT && g_keep && ((g_who == 1) ? if_req : m_req)) begin
          if (g_who == 1) begin e.if_done = 1; e.if_rdata = mem_rdata; e.if_err = mem_err; end
          else            begin e.m_done  = 1; e.m_rdata  = mem_rdata; e.m_err  = mem_err; end
        end
      end else if (pick() == 1) begin
        e.mem_rd = 1; e.mem_addr = if_addr;
      end else if (pick() == 2) begin
        e.mem_addr = m_addr;
        if (m_wr) begin e.mem_wr = 1; e.mem_wdata = m_wdata; end
        else e.mem_rd = 1;
      end
    end
    e.stall_f = if_req & ~e.if_done;
    e.stall_m = m_req & ~e.m_done;
    return e;
  endfunction

  always @(posedge clk) now <= now + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_who <= 0; g_keep <= 0; last_m <= 0;
    end else if (g_who != 0) begin
      if (!((g_who == 1) ? if_req : m_req)) g_keep <= 0;
      if (now == g_time + LAT) g_who <= 0;
    end else if (pick() != 0) begin
      g_who <= pick(); g_time <= now; g_keep <= 1; last_m <= (pick() == 2);
    end
  end

  // ---------------- helpers ----------------
  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    if_req = 0; m_req = 0; m_wr = 0;
    repeat (n) edge1();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 0; if_req = 1; if_addr = 16'h1111; m_req = 0; m_wr = 0;
    m_addr = 0; m_wdata = 0; mem_rdata = 16'hCAFE; mem_err = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_rd, mem_wr, mem_addr, mem_wdata, if_done, if_err, if_rdata, m_done, m_err, m_rdata} !== 70'h0) begin
        errors++; $display("FAIL reset_outs cyc%0d rd=%b wr=%b addr=%h if_done=%b m_done=%b, want all 0", i, mem_rd, mem_wr, mem_addr, if_done, m_done);
      end
      checks++;
      if (stall_f !== 1'b1) begin errors++; $display("FAIL reset_stall_f got %b want 1", stall_f); end
    end
    edge1(); rst = 1;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h1111) begin
          errors++; $display("FAIL reset_first_grant rd=%b addr=%h want 1/1111", mem_rd, mem_addr);
        end
      end
      checks++;
      if (if_done !== (k == LAT) || stall_f !== (k != LAT)) begin
        errors++; $display("FAIL reset_done k=%0d if_done=%b stall_f=%b want %b/%b", k, if_done, stall_f, k == LAT, k != LAT);
      end
      if (k == LAT) begin
        checks++;
        if (if_rdata !== 16'hCAFE) begin errors++; $display("FAIL reset_rdata got %h want cafe", if_rdata); end
      end
      edge1();
    end
    if_req = 0;
  endtask

  task automatic test_fetch_read();
    if_req = 1; if_addr = 16'h0010;
    for (int k = 0; k <= LAT + 1; k++) begin
      mem_rdata = (k == LAT) ? 16'h1234 : 16'($urandom);
      @(negedge clk);
      if (k < LAT) begin
        checks++;
        if (stall_f !== 1'b1 || if_done !== 1'b0) begin
          errors++; $display("FAIL fetch_stall k=%0d stall_f=%b if_done=%b want 1/0", k, stall_f, if_done);
        end
      end
      if (k == 0) begin
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0010) begin
          errors++; $display("FAIL fetch_cmd rd=%b addr=%h want 1/0010", mem_rd, mem_addr);
        end
      end else if (k <= LAT) begin
        checks++;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
          errors++; $display("FAIL fetch_no_cmd k=%0d rd=%b wr=%b want 0/0", k, mem_rd, mem_wr);
        end
      end
      if (k == LAT) begin
        checks++;
        if (if_done !== 1'b1 || if_rdata !== 16'h1234 || stall_f !== 1'b0) begin
          errors++; $display("FAIL fetch_done done=%b rdata=%h stall=%b want 1/1234/0", if_done, if_rdata, stall_f);
        end
      end
      if (k == LAT + 1) begin
        checks++;
        if (mem_rd !== 1'b1) begin errors++; $display("FAIL fetch_regrant rd=%b want 1", mem_rd); end
      end
      edge1();
    end
    idle(LAT + 1);
  endtask

  task automatic test_contention();
    if_req = 1; m_req = 1; m_wr = 0; m_addr = 16'h0100; if_addr = 16'h0020;
    for (int k = 0; k < 4 * (LAT + 1); k++) begin
      logic        exp_rd;
      logic [15:0] exp_addr;
      mem_rdata = 16'($urandom);
      exp_rd   = (k % (LAT + 1) == 0);
      exp_addr = !exp_rd ? 16'h0 : ((k / (LAT + 1)) % 2 == 0) ? 16'h0100 : 16'h0020;
      @(negedge clk);
      checks++;
      if (mem_rd !== exp_rd || mem_addr !== exp_addr || mem_wr !== 1'b0) begin
        errors++; $display("FAIL contend_grant k=%0d rd=%b addr=%h wr=%b want %b/%h/0", k, mem_rd, mem_addr, mem_wr, exp_rd, exp_addr);
      end
      checks++;
      if (m_done !== (k == 4 || k == 14) || if_done !== (k == 9 || k == 19)) begin
        errors++; $display("FAIL contend_done k=%0d m_done=%b if_done=%b", k, m_done, if_done);
      end
      edge1();
    end
    idle(1);
  endtask

  task automatic test_store();
    m_req = 1; m_wr = 1; m_addr = 16'h00A0; m_wdata = 16'hBEEF;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      checks++;
      if (k == 0) begin
        if ({mem_wr, mem_rd, mem_addr, mem_wdata} !== {1'b1, 1'b0, 16'h00A0, 16'hBEEF}) begin
          errors++; $display("FAIL store_cmd wr=%b rd=%b addr=%h wdata=%h want 1/0/00a0/beef", mem_wr, mem_rd, mem_addr, mem_wdata);
        end
      end else if ({mem_wr, mem_rd, mem_addr, mem_wdata} !== 34'h0) begin
        errors++; $display("FAIL store_quiet k=%0d wr=%b rd=%b addr=%h wdata=%h want 0", k, mem_wr, mem_rd, mem_addr, mem_wdata);
      end
      checks++;
      if (m_done !== (k == LAT) || stall_m !== (k != LAT)) begin
        errors++; $display("FAIL store_done k=%0d m_done=%b stall_m=%b", k, m_done, stall_m);
      end
      edge1();
    end
    idle(1);
  endtask

  task automatic test_flush();
    if_req = 1; if_addr = 16'h0040; m_req = 0; m_wr = 0;
    for (int k = 0; k <= 2 * LAT + 1; k++) begin
      if (k == 2) begin if_req = 0; m_req = 1; m_addr = 16'h0300; end
      @(negedge clk);
      checks++;
      if (if_done !== 1'b0) begin errors++; $display("FAIL flush_no_done k=%0d if_done=%b want 0", k, if_done); end
      checks++;
      if (mem_rd !== (k == 0 || k == LAT + 1)) begin
        errors++; $display("FAIL flush_cmd k=%0d rd=%b", k, mem_rd);
      end
      if (k == LAT + 1) begin
        checks++;
        if (mem_addr !== 16'h0300) begin errors++; $display("FAIL flush_m_addr got %h want 0300", mem_addr); end
      end
      checks++;
      if (m_done !== (k == 2 * LAT + 1)) begin errors++; $display("FAIL flush_m_done k=%0d got %b", k, m_done); end
      edge1();
    end
    idle(1);
  endtask

  task automatic test_err_reset();
    m_req = 1; m_wr = 0; m_addr = 16'h0500;
    for (int k = 0; k <= LAT; k++) begin
      mem_err   = (k == LAT);
      mem_rdata = (k == LAT) ? 16'h5A5A : 16'($urandom);
      @(negedge clk);
      if (k == LAT) begin
        checks++;
        if (m_done !== 1'b1 || m_err !== 1'b1 || m_rdata !== 16'h5A5A) begin
          errors++; $display("FAIL err_flag done=%b err=%b rdata=%h want 1/1/5a5a", m_done, m_err, m_rdata);
        end
      end
      edge1();
    end
    mem_err = 0; idle(1);
    // reset in the middle of a fetch, then keep requesting after release
    if_req = 1; if_addr = 16'h0060;
    edge1(); edge1();
    rst = 0;
    #1;
    checks++;
    if ({mem_rd, mem_wr, mem_addr, mem_wdata, if_done, if_err, if_rdata, m_done, m_err, m_rdata} !== 70'h0 || stall_f !== 1'b1) begin
      errors++; $display("FAIL midreset_outs rd=%b addr=%h if_done=%b stall_f=%b want 0/0/0/1", mem_rd, mem_addr, if_done, stall_f);
    end
    edge1(); rst = 1;
    for (int k = 3; k <= 3 + LAT; k++) begin
      @(negedge clk);
      checks++;
      if (mem_rd !== (k == 3) || if_done !== (k == 3 + LAT)) begin
        errors++; $display("FAIL midreset_after k=%0d rd=%b if_done=%b want %b/%b", k, mem_rd, if_done, k == 3, k == 3 + LAT);
      end
      edge1();
    end
    idle(1);
  endtask

  task automatic test_random();
    exp_t e, a;
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 60) != 0);
      if_req    = ($urandom_range(0, 3) != 0);
      m_req     = ($urandom_range(0, 3) != 0);
      m_wr      = 1'($urandom);
      if_addr   = 16'($urandom);
      m_addr    = 16'($urandom);
      m_wdata   = 16'($urandom);
      mem_rdata = 16'($urandom);
      mem_err   = 1'($urandom);
      @(negedge clk);
      e = model_exp();
      a = exp_t'({mem_rd, mem_wr, mem_addr, mem_wdata, if_done, if_err, if_rdata,
                  m_done, m_err, m_rdata, stall_f, stall_m});
      checks++;
      if (a !== e) begin
        errors++; $display("FAIL random n=%0d got %h want %h", n, a, e);
      end
      edge1();
    end
    rst = 1; idle(LAT + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fetch_read();
    test_contention();
    test_store();
    test_flush();
    test_err_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
